// File: rtl/lru_read_cache_if.sv
// ---------------------------------------------------------------------------
// lru_read_cache_if
//
// Bundles the two AXI4 read paths seen by lru_read_cache:
//   s_axi_* : narrow frontend read port (user logic is the AXI master)
//   m_axi_* : wide backend line-fill port (memory path is the AXI slave)
//
// Modports:
//   slave  - the cache's view: it is the slave of the frontend
//            and drives the backend request.
//   master - the environment's view: frontend requester plus backend memory.
// ---------------------------------------------------------------------------
interface lru_read_cache_if #(
    parameter int ADDR_WIDTH    = 48,
    parameter int FE_DATA_WIDTH = 64,
    parameter int BE_DATA_WIDTH = 512,
    parameter int ID_WIDTH      = 1
);
    // Frontend AR / R
    logic                     s_axi_arvalid;
    logic                     s_axi_arready;
    logic [ADDR_WIDTH-1:0]    s_axi_araddr;
    logic [ID_WIDTH-1:0]      s_axi_arid;
    logic                     s_axi_rvalid;
    logic                     s_axi_rready;
    logic [FE_DATA_WIDTH-1:0] s_axi_rdata;
    logic [ID_WIDTH-1:0]      s_axi_rid;
    logic [1:0]               s_axi_rresp;
    logic                     s_axi_rlast;

    // Backend AR / R
    logic                     m_axi_arvalid;
    logic                     m_axi_arready;
    logic [ADDR_WIDTH-1:0]    m_axi_araddr;
    logic [7:0]               m_axi_arlen;
    logic [2:0]               m_axi_arsize;
    logic [1:0]               m_axi_arburst;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;
    logic [BE_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]               m_axi_rresp;

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_rready,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rid,
        output s_axi_rresp, s_axi_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        output m_axi_arburst, m_axi_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
    );

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_rready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rid,
        input  s_axi_rresp, s_axi_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        input  m_axi_arburst, m_axi_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp
    );
endinterface

// File: rtl/lru_read_cache.sv
// ---------------------------------------------------------------------------
// lru_read_cache
//
// N-way set-associative read-only cache with true-LRU replacement. Single-beat
// frontend reads are served from a register-based line store; a miss issues
// one full-line backend read and fills the LRU victim way. One request is in
// flight at a time.
//
// Ports:
//   axis_aclk    - clock
//   axis_aresetn - asynchronous active-low reset
//   bus          - lru_read_cache_if.slave (frontend s_axi_*, backend m_axi_*)
//   flush_req    - level; invalidates every line when seen in IDLE
//   stat_hits    - completed-hit counter (0 unless LRU_CACHE_STATS_EN)
//   stat_misses  - miss counter, error fills included (0 unless LRU_CACHE_STATS_EN)
//
// Optional feature: define LRU_CACHE_STATS_EN to build the saturating
// hit/miss counters; otherwise both stat outputs are constant zero.
// ---------------------------------------------------------------------------
module lru_read_cache #(
    parameter int ADDR_WIDTH    = 48,
    parameter int SETS          = 16,
    parameter int WAYS          = 4,
    parameter int FE_DATA_WIDTH = 64,
    parameter int BE_DATA_WIDTH = 512,
    parameter int ID_WIDTH      = 1
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    lru_read_cache_if.slave   bus,
    input  logic              flush_req,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);
    localparam int OFF_W    = $clog2(BE_DATA_WIDTH / 8);
    localparam int FE_OFF_W = $clog2(FE_DATA_WIDTH / 8);
    localparam int WSEL_W   = OFF_W - FE_OFF_W;
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W    = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP} state_t;
    state_t state, state_nxt;

    // Line store and replacement state
    logic                     valid [SETS][WAYS];
    logic [TAG_W-1:0]         tags  [SETS][WAYS];
    logic [BE_DATA_WIDTH-1:0] lines [SETS][WAYS];
    logic [WAY_W-1:0]         ages  [SETS][WAYS];

    // Accepted request; the byte offset within a frontend word is never used
    logic [ADDR_WIDTH-1:FE_OFF_W] req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_wsel = req_addr[OFF_W-1:FE_OFF_W];

    logic [WAY_W-1:0]         victim;
    logic [FE_DATA_WIDTH-1:0] rdata;
    logic [1:0]               rresp;
    logic [ID_WIDTH-1:0]      rid;

    function automatic logic [FE_DATA_WIDTH-1:0] word_sel(
        input logic [BE_DATA_WIDTH-1:0] line, input logic [WSEL_W-1:0] sel);
        return line[int'(sel) * FE_DATA_WIDTH +: FE_DATA_WIDTH];
    endfunction

    // Tag match across the addressed set
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest (age WAYS-1)
    logic             have_inv;
    logic [WAY_W-1:0] victim_nxt;
    always_comb begin
        have_inv   = 1'b0;
        victim_nxt = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                have_inv   = 1'b1;
                victim_nxt = WAY_W'(w);
            end
        end
        if (!have_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[req_idx][w] == WAY_W'(WAYS - 1)) victim_nxt = WAY_W'(w);
            end
        end
    end

    logic ar_fire, lookup_hit, be_r_fire, fill_ok, flush_en, touch_en;
    logic [WAY_W-1:0] touch_way;
    assign ar_fire    = bus.s_axi_arvalid && bus.s_axi_arready;
    assign lookup_hit = (state == LOOKUP) && hit;
    assign be_r_fire  = (state == MISS_R) && bus.m_axi_rvalid;
    assign fill_ok    = be_r_fire && (bus.m_axi_rresp == 2'b00);
    assign flush_en   = (state == IDLE) && flush_req;
    assign touch_en   = lookup_hit || fill_ok;
    assign touch_way  = lookup_hit ? hit_way : victim;

    // FSM state register
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state <= IDLE;
        else               state <= state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt         = state;
        bus.s_axi_arready = 1'b0;
        bus.s_axi_rvalid  = 1'b0;
        bus.m_axi_arvalid = 1'b0;
        bus.m_axi_rready  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.s_axi_arready = !flush_req;
                if (ar_fire) state_nxt = LOOKUP;
            end
            LOOKUP:  state_nxt = hit ? RESP : MISS_AR;
            MISS_AR: begin
                bus.m_axi_arvalid = 1'b1;
                if (bus.m_axi_arready) state_nxt = MISS_R;
            end
            MISS_R: begin
                bus.m_axi_rready = 1'b1;
                if (bus.m_axi_rvalid) state_nxt = RESP;
            end
            RESP: begin
                bus.s_axi_rvalid = 1'b1;
                if (bus.s_axi_rready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and frontend response payload
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            req_addr <= '0;
            victim   <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rid      <= '0;
        end else begin
            if (ar_fire) begin
                req_addr <= bus.s_axi_araddr[ADDR_WIDTH-1:FE_OFF_W];
                rid      <= bus.s_axi_arid;
            end
            if (state == LOOKUP) victim <= victim_nxt;
            if (lookup_hit) begin
                rdata <= word_sel(lines[req_idx][hit_way], req_wsel);
                rresp <= 2'b00;
            end
            if (be_r_fire) begin
                // Error fills return zero data and forward the backend response
                rdata <= fill_ok ? word_sel(bus.m_axi_rdata, req_wsel) : '0;
                rresp <= bus.m_axi_rresp;
            end
        end
    end

    // Valid bits and LRU ages; ages in a set stay a permutation of 0..WAYS-1
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    ages[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            if (flush_en) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
                end
            end
            if (fill_ok) valid[req_idx][victim] <= 1'b1;
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        ages[req_idx][w] <= '0;
                    else if (ages[req_idx][w] < ages[req_idx][touch_way])
                        ages[req_idx][w] <= ages[req_idx][w] + 1'b1;
                end
            end
        end
    end

    // Line data and tags carry no reset; valid bits qualify them
    always_ff @(posedge axis_aclk) begin
        if (fill_ok) begin
            lines[req_idx][victim] <= bus.m_axi_rdata;
            tags[req_idx][victim]  <= req_tag;
        end
    end

    assign bus.s_axi_rdata   = rdata;
    assign bus.s_axi_rresp   = rresp;
    assign bus.s_axi_rid     = rid;
    assign bus.s_axi_rlast   = bus.s_axi_rvalid;
    assign bus.m_axi_araddr  = {req_tag, req_idx, {OFF_W{1'b0}}};
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = 3'(OFF_W);
    assign bus.m_axi_arburst = 2'b01;

`ifdef LRU_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_cnt != 32'hFFFF_FFFF)    hit_cnt  <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != 32'hFFFF_FFFF)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
    assign stat_hits   = hit_cnt;
    assign stat_misses = miss_cnt;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_lru_read_cache.sv
// ---------------------------------------------------------------------------
// tb_lru_read_cache
//
// Directed bench for lru_read_cache with default parameters. A table of
// frontend reads (address, ID, backend response, expected hit/miss, data,
// response) is applied in order; the bench acts as the backend memory,
// returning line words of the form {line_addr[31:0], 28'h0, word_index}.
// Hand-written sequences cover reset, flush, a stalled response and an
// asynchronous reset in the middle of a fill.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lru_read_cache;
    localparam int AW = 48;
    localparam int FW = 64;
    localparam int BW = 512;
    localparam int IW = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_req;
    logic [31:0] stat_hits, stat_misses;

    lru_read_cache_if #(.ADDR_WIDTH(AW), .FE_DATA_WIDTH(FW), .BE_DATA_WIDTH(BW),
                        .ID_WIDTH(IW)) bus ();

    lru_read_cache #(.ADDR_WIDTH(AW), .SETS(16), .WAYS(4), .FE_DATA_WIDTH(FW),
                     .BE_DATA_WIDTH(BW), .ID_WIDTH(IW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .bus          (bus),
        .flush_req    (flush_req),
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] line_data(input logic [AW-1:0] la);
        logic [BW-1:0] l;
        for (int w = 0; w < BW / FW; w++) l[w*FW +: FW] = {la[31:0], 28'h0, 4'(w)};
        return l;
    endfunction

    // One complete frontend read, with the bench answering any backend fill.
    task automatic do_read(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [1:0] be_resp, input string tag,
                           output bit miss, output int first_cyc, output int r_lat,
                           output logic [FW-1:0] rdata, output logic [1:0] rresp,
                           output logic [IW-1:0] rid);
        int cyc;
        logic [AW-1:0] line;
        line = {addr[AW-1:6], 6'b0};
        miss = 1'b0; first_cyc = 0; r_lat = 0; rdata = '0; rresp = '0; rid = '0;
        cyc = 0;
        while (!bus.s_axi_arready && cyc < 50) begin @(negedge clk); cyc++; end
        bus.s_axi_rready  = 1'b1;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arid    = id;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        cyc = 1;
        while (!bus.s_axi_rvalid && !bus.m_axi_arvalid && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        first_cyc = cyc;
        if (bus.m_axi_arvalid) begin
            miss = 1'b1;
            check({tag, " be araddr"}, 64'(bus.m_axi_araddr), 64'(line));
            check({tag, " be ar const"}, 64'({bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst}),
                  64'({8'd0, 3'd6, 2'b01}));
            // Backend stalls arready one cycle; request must be held
            @(negedge clk);
            check({tag, " be ar held"}, 64'({bus.m_axi_arvalid, bus.m_axi_araddr}), 64'({1'b1, line}));
            bus.m_axi_arready = 1'b1;
            @(negedge clk);
            bus.m_axi_arready = 1'b0;
            check({tag, " be rready"}, 64'(bus.m_axi_rready), 64'd1);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = line_data(line);
            bus.m_axi_rresp  = be_resp;
            @(negedge clk);
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rdata  = '0;
            bus.m_axi_rresp  = 2'b00;
            r_lat = 1;
            while (!bus.s_axi_rvalid && r_lat < 50) begin @(negedge clk); r_lat++; end
        end
        check({tag, " rvalid"}, 64'(bus.s_axi_rvalid), 64'd1);
        check({tag, " rlast"}, 64'(bus.s_axi_rlast), 64'd1);
        rdata = bus.s_axi_rdata;
        rresp = bus.s_axi_rresp;
        rid   = bus.s_axi_rid;
        @(negedge clk);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    be_resp;
        bit            exp_miss;
        logic [FW-1:0] exp_rdata;
        logic [1:0]    exp_rresp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            miss;
        int            fc, rl;
        logic [FW-1:0] rd;
        logic [1:0]    rr;
        logic [IW-1:0] ri;
        int            exp_hits, exp_misses;

        rst_n = 1'b0;
        flush_req = 1'b0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arid = '0;
        bus.s_axi_rready = 1'b0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst arready", 64'(bus.s_axi_arready), 64'd1);
        check("rst rvalid",  64'(bus.s_axi_rvalid),  64'd0);
        check("rst m_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("rst m_rready",  64'(bus.m_axi_rready),  64'd0);
        check("rst payload", 64'({bus.s_axi_rdata}), 64'd0);
        check("rst rresp/rid", 64'({bus.s_axi_rresp, bus.s_axi_rid}), 64'd0);
        check("rst stats", 64'({stat_hits, stat_misses}), 64'd0);

        // Set 0 holds lines 0x1000..0x5000; ages traced by hand through each touch
        vecs[0]  = '{48'h1000, 2'b00, 1'b1, 64'h0000_1000_0000_0000, 2'b00};
        vecs[1]  = '{48'h1008, 2'b00, 1'b0, 64'h0000_1000_0000_0001, 2'b00};
        vecs[2]  = '{48'h2000, 2'b00, 1'b1, 64'h0000_2000_0000_0000, 2'b00};
        vecs[3]  = '{48'h3000, 2'b00, 1'b1, 64'h0000_3000_0000_0000, 2'b00};
        vecs[4]  = '{48'h4000, 2'b00, 1'b1, 64'h0000_4000_0000_0000, 2'b00};
        vecs[5]  = '{48'h1010, 2'b00, 1'b0, 64'h0000_1000_0000_0002, 2'b00};
        vecs[6]  = '{48'h5018, 2'b00, 1'b1, 64'h0000_5000_0000_0003, 2'b00};
        vecs[7]  = '{48'h2008, 2'b00, 1'b1, 64'h0000_2000_0000_0001, 2'b00};
        vecs[8]  = '{48'h1038, 2'b00, 1'b0, 64'h0000_1000_0000_0007, 2'b00};
        vecs[9]  = '{48'h4020, 2'b00, 1'b0, 64'h0000_4000_0000_0004, 2'b00};
        vecs[10] = '{48'h3000, 2'b00, 1'b1, 64'h0000_3000_0000_0000, 2'b00};
        vecs[11] = '{48'h5000, 2'b00, 1'b1, 64'h0000_5000_0000_0000, 2'b00};
        vecs[12] = '{48'h1000, 2'b00, 1'b0, 64'h0000_1000_0000_0000, 2'b00};
        vecs[13] = '{48'h8040, 2'b10, 1'b1, 64'h0,                   2'b10};
        vecs[14] = '{48'h8040, 2'b00, 1'b1, 64'h0000_8040_0000_0000, 2'b00};
        vecs[15] = '{48'h8048, 2'b00, 1'b0, 64'h0000_8040_0000_0001, 2'b00};

        exp_hits = 0;
        exp_misses = 0;
        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_read(vecs[i].addr, IW'(i % 2), vecs[i].be_resp, t, miss, fc, rl, rd, rr, ri);
            check({t, " miss"}, 64'(miss), 64'(vecs[i].exp_miss));
            check({t, " first event cycle"}, 64'(fc), 64'd2);
            if (vecs[i].exp_miss) check({t, " rvalid after be R"}, 64'(rl), 64'd1);
            check({t, " rdata"}, rd, vecs[i].exp_rdata);
            check({t, " rresp"}, 64'(rr), 64'(vecs[i].exp_rresp));
            check({t, " rid"}, 64'(ri), 64'(i % 2));
            if (vecs[i].exp_miss) exp_misses++; else exp_hits++;
        end

`ifdef LRU_CACHE_STATS_EN
        check("stat_hits", 64'(stat_hits), 64'(exp_hits));
        check("stat_misses", 64'(stat_misses), 64'(exp_misses));
`else
        check("stat_hits off", 64'(stat_hits), 64'd0);
        check("stat_misses off", 64'(stat_misses), 64'd0);
`endif

        // Flush: arready drops in the flush cycle, then every line misses
        flush_req = 1'b1;
        #1;
        check("flush arready", 64'(bus.s_axi_arready), 64'd0);
        @(negedge clk);
        flush_req = 1'b0;
        do_read(48'h1000, 1'b0, 2'b00, "fl0", miss, fc, rl, rd, rr, ri);
        check("fl0 miss", 64'(miss), 64'd1);
        check("fl0 rdata", rd, 64'h0000_1000_0000_0000);
        do_read(48'h4000, 1'b0, 2'b00, "fl1", miss, fc, rl, rd, rr, ri);
        check("fl1 miss", 64'(miss), 64'd1);
        do_read(48'h8048, 1'b1, 2'b00, "fl2", miss, fc, rl, rd, rr, ri);
        check("fl2 miss", 64'(miss), 64'd1);
        check("fl2 rdata", rd, 64'h0000_8040_0000_0001);

        // Stalled hit response: payload stable, no new request accepted
        bus.s_axi_rready  = 1'b0;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr  = 48'h1008;
        bus.s_axi_arid    = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall%0d rvalid", c), 64'(bus.s_axi_rvalid), 64'd1);
            check($sformatf("stall%0d rdata", c), bus.s_axi_rdata, 64'h0000_1000_0000_0001);
            check($sformatf("stall%0d arready", c), 64'(bus.s_axi_arready), 64'd0);
            @(negedge clk);
        end
        check("stall rid", 64'(bus.s_axi_rid), 64'd1);
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        check("stall release rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        check("stall release arready", 64'(bus.s_axi_arready), 64'd1);

        // Asynchronous reset while the fill request is outstanding
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr  = 48'h9000;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("midrst m_arvalid before", 64'(bus.m_axi_arvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst m_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("midrst rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst arready", 64'(bus.s_axi_arready), 64'd1);
        check("midrst stats", 64'({stat_hits, stat_misses}), 64'd0);
        do_read(48'h1008, 1'b0, 2'b00, "postrst", miss, fc, rl, rd, rr, ri);
        check("postrst miss", 64'(miss), 64'd1);
        check("postrst rdata", rd, 64'h0000_1000_0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/lru_read_cache.md
# lru_read_cache

Parametrised N-way set-associative read-only cache with true-LRU replacement, sitting in box_250mhz between a narrow AXI4 read master (user logic, 64-bit) and a wide AXI4 read slave (memory path, 512-bit). Single-beat frontend reads hit in the register-based line store or trigger one full-line backend fill into the LRU victim way. One outstanding miss; write channels are not part of this block.

## Interface
Parameters:
- ADDR_WIDTH, 48, byte address width, both sides
- SETS, 16, number of sets, power of two, >=2
- WAYS, 4, associativity, power of two, >=2
- FE_DATA_WIDTH, 64, frontend data width (bits)
- BE_DATA_WIDTH, 512, backend data width = line size (bits)
- ID_WIDTH, 1, frontend ID width

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  async active-low reset
- s_axi_arvalid/arready  in/out  1  frontend AR handshake
- s_axi_araddr  in  ADDR_WIDTH  read byte address, FE-word aligned
- s_axi_arid  in  ID_WIDTH  transaction ID
- s_axi_rvalid  out  1 / s_axi_rready  in  1  frontend R handshake
- s_axi_rdata  out  FE_DATA_WIDTH  read word
- s_axi_rid  out  ID_WIDTH  returned ID
- s_axi_rresp  out  2  OKAY or forwarded backend error
- s_axi_rlast  out  1  always 1 with rvalid
- m_axi_arvalid  out  1 / m_axi_arready  in  1  backend AR handshake
- m_axi_araddr  out  ADDR_WIDTH  line-aligned fill address
- m_axi_arlen  out  8  constant 0
- m_axi_arsize  out  3  constant log2(BE_DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01
- m_axi_rvalid  in  1 / m_axi_rready  out  1  backend R handshake
- m_axi_rdata  in  BE_DATA_WIDTH  fill line
- m_axi_rresp  in  2  fill response
- flush_req  in  1  level; invalidate all lines
- stat_hits, stat_misses  out  32  counters (see Configuration)

## Operation
- Address split: OFF_W=log2(BE_DATA_WIDTH/8); WSEL = araddr[OFF_W-1:log2(FE_DATA_WIDTH/8)]; IDX = next log2(SETS) bits; TAG = remaining ADDR_WIDTH-OFF_W-log2(SETS) bits.
- State per way per set: valid, tag, line, age (log2(WAYS) bits).
- FSM IDLE -> LOOKUP -> (hit) RESP -> IDLE; LOOKUP -> (miss) MISS_AR -> MISS_R -> RESP -> IDLE.
- IDLE: s_axi_arready=1 unless flush_req=1; accept registers addr and ID.
- LOOKUP: compare tag against all valid ways of set IDX; at most one match.
- Hit: rdata = matched line word WSEL, rresp=OKAY, touch matched way.
- Miss: victim = lowest-index invalid way, else way with age WAYS-1. MISS_AR drives m_axi_araddr = {TAG,IDX,OFF_W'b0} until arready. MISS_R holds m_axi_rready=1; on beat with rresp=OKAY write line/tag/valid into victim, touch victim, return word WSEL. On rresp!=OKAY: no allocation, no age change, rdata=0, s_axi_rresp=m_axi_rresp.
- Touch of way w with age a: every way in set with age<a increments; way w age := 0. Ages in a set always form a permutation of 0..WAYS-1.
- Flush: when flush_req=1 in IDLE, all valid bits cleared in one cycle, ages untouched; arready=0 that cycle. flush_req outside IDLE waits until IDLE.
- Reset: all valid=0, age of way i = i, FSM=IDLE, all valid/ready outputs 0 except s_axi_arready=1 after reset release; rdata/rresp/rid 0; counters 0.

## Timing
- Hit latency: AR accept cycle N, s_axi_rvalid at N+2.
- Miss: m_axi_arvalid at N+2; s_axi_rvalid one cycle after the m_axi R handshake.
- s_axi_rvalid and payload held stable until rready; arready low from accept until R handshake completes.
- Async reset mid-miss abandons the fill; backend beats arriving afterward are accepted only via a new request (implementation must not assume otherwise from backend).

## Configuration
- LRU_CACHE_STATS_EN defined: stat_hits/stat_misses increment once per completed hit / per miss (including error fills), saturating at 32'hFFFF_FFFF, cleared by reset only.
- Undefined: both outputs tied to 0, no counter flops.

## Test plan
- Cold read 0x1000 -> one backend AR at 0x1000, fill data word 0 returned, rresp=OKAY, misses=1.
- Repeat read 0x1008 -> no backend AR, rvalid 2 cycles after accept, word 1 of line, hits=1.
- 5 distinct tags into set 0 (WAYS=4), re-touch first before fifth -> fifth evicts second-oldest; re-reading it misses.
- Backend rresp=2'b10 on fill -> frontend rresp=2'b10, rdata=0; next read same address misses again.
- flush_req pulse after filling 4 lines -> all subsequent reads miss.
- s_axi_rready held low 10 cycles on a hit -> rvalid/rdata stable, arready low throughout.
